// File: rtl/bf_pkg.sv
// bf_pkg: types and constants shared by the brainfuck processor and its I/O blocks.
package bf_pkg;

    localparam int unsigned BF_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/stdin_fifo.sv
// stdin_fifo: circular byte buffer with a registered head, used by uart_stdin
// only when UART_STDIN_FIFO_EN is defined.
`ifdef UART_STDIN_FIFO_EN
module stdin_fifo
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push_i,
    input  logic [BF_BYTE_W-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [BF_BYTE_W-1:0] rdata_o,
    output logic                 valid_o,
    output logic                 full_c
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [BF_BYTE_W-1:0] mem_q [DEPTH];
    logic [BF_BYTE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [BF_BYTE_W-1:0] rdata_q, rdata_d;
    logic                 valid_q, valid_d;
    logic                 push_ok_c;
    logic                 pop_ok_c;

    assign full_c = (wr_q[IDX_W] != rd_q[IDX_W]) &&
                    (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        pop_ok_c  = pop_i && valid_q;
        push_ok_c = push_i && (!full_c || pop_ok_c);
        if (push_ok_c) begin
            mem_d[wr_q[IDX_W-1:0]] = wdata_i;
            wr_d                   = wr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_d = rd_q + PTR_W'(1);
        end
        valid_d = (wr_d != rd_d);
        rdata_d = mem_d[rd_d[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;

endmodule
`endif

// File: rtl/uart_stdin.sv
// uart_stdin: 8N1 serial receiver that holds bytes for the processor's stdin port.
// UART_STDIN_FIFO_EN selects a FIFO_DEPTH-entry buffer; default is a single holding register.
module uart_stdin
    import bf_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [BF_BYTE_W-1:0] stdin,
    output logic                 stdin_valid,
    input  logic                 stdin_ren,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_stdin: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [1:0]           rx_live_q, rx_live_d;
    logic                 prev_q, prev_d;
    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [BF_BYTE_W-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;
    logic                 fall_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 full_c;

    assign rx_s   = sync2_q;
    assign fall_c = prev_q & ~rx_s;
    assign pop_c  = stdin_ren & stdin_valid;

    // rx_live marks when rx_s carries real line samples rather than the synchronizer's
    // reset value, so a line held low through reset release never looks like a start edge.
    always_comb begin
        sync1_d     = rx;
        sync2_d     = sync1_q;
        rx_live_d   = {rx_live_q[0], 1'b1};
        prev_d      = rx_s & rx_live_q[1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = BIT_LOAD;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[BF_BYTE_W-1:1]};
                    cnt_d   = BIT_LOAD;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    push_c      = rx_s;
                    frame_err_d = ~rx_s;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = overrun_q;
        if (pop_c) begin
            overrun_d = 1'b0;
        end else if (push_c && full_c) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_live_q   <= 2'b00;
            prev_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_live_q   <= rx_live_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_STDIN_FIFO_EN
    stdin_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .wdata_i (shift_q),
        .pop_i   (pop_c),
        .rdata_o (stdin),
        .valid_o (stdin_valid),
        .full_c  (full_c)
    );
`else
    logic [BF_BYTE_W-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;

    // Depth-1 buffer: a push replaces the head only when it is empty or being popped.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (push_c && (!hold_valid_q || pop_c)) begin
            hold_d       = shift_q;
            hold_valid_d = 1'b1;
        end else if (pop_c) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign full_c      = hold_valid_q;
    assign stdin       = hold_q;
    assign stdin_valid = hold_valid_q;
`endif

endmodule

// File: tb/tb_uart_stdin.sv
// tb_uart_stdin: self-checking bench for uart_stdin; buffer depth follows UART_STDIN_FIFO_EN.
module tb_uart_stdin;

    localparam int unsigned C = 4;
`ifdef UART_STDIN_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] stdin;
    logic       stdin_valid;
    logic       stdin_ren;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;

    logic [7:0] mq[$];
    logic       ov_m;

    uart_stdin #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .stdin       (stdin),
        .stdin_valid (stdin_valid),
        .stdin_ren   (stdin_ren),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full frame; returns in the cycle where the stop bit is sampled.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) tick();
        end
        rx = stop_bit;
        repeat (C) tick();
        rx = 1'b1;
    endtask

    task automatic pop();
        stdin_ren = 1'b1;
        tick();
        stdin_ren = 1'b0;
    endtask

    task automatic test_reset();
        int fe0;
        reset_n = 1'b0;
        rx      = 1'b0;
        repeat (3) tick();
        checks++; if (stdin !== 8'h00) begin errors++; $display("FAIL reset_stdin: got %h expected 00", stdin); end
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", stdin_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        fe0 = fe_cnt;
        reset_n = 1'b1;
        repeat (60) tick();
        rx = 1'b1;
        repeat (20) tick();
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL low_at_release_valid: got %b expected 0", stdin_valid); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL low_at_release_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_single();
        send_frame(8'h41, 1'b1);
        // This is the stop-sample cycle E+H+9C; the byte must not be visible yet.
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", stdin_valid); end
        tick();
        checks++; if (stdin_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", stdin_valid); end
        checks++; if (stdin !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", stdin); end
        pop();
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", stdin_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (30) tick();
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", stdin_valid); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
        send_frame(8'h55, 1'b1);
        repeat (3) tick();
        checks++; if (stdin_valid !== 1'b1 || stdin !== 8'h55) begin errors++; $display("FAIL glitch_next: got v=%b d=%h expected v=1 d=55", stdin_valid, stdin); end
        pop();
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h7E, 1'b0);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_early: got %b expected 0", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b expected 1", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_end: got %b expected 0", frame_err); end
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", stdin_valid); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d pulses expected 1", fe_cnt - fe0); end
        repeat (2) tick();
        send_frame(8'h31, 1'b1);
        repeat (3) tick();
        checks++; if (stdin_valid !== 1'b1 || stdin !== 8'h31) begin errors++; $display("FAIL ferr_next: got v=%b d=%h expected v=1 d=31", stdin_valid, stdin); end
        pop();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1);
            repeat (3) tick();
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (stdin !== 8'h01) begin errors++; $display("FAIL ovr_head: got %h expected 01", stdin); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (stdin_valid !== 1'b1 || stdin !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d: got v=%b d=%h expected v=1 d=%h", i, stdin_valid, stdin, 8'(i)); end
            pop();
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear%0d: got %b expected 0", i, overrun); end
        end
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", stdin_valid); end
    endtask

    task automatic test_simul_pop();
        send_frame(8'h10, 1'b1);
        repeat (3) tick();
        send_frame(8'h20, 1'b1);
        // Pop in the stop-sample cycle so the pop and the 0x20 push share a clock edge.
        pop();
        checks++; if (stdin !== 8'h20) begin errors++; $display("FAIL simul_data: got %h expected 20", stdin); end
        checks++; if (stdin_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b expected 1", stdin_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
        pop();
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b expected 0", stdin_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] hd;
        mq.delete();
        ov_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (mq.size() < DEPTH) mq.push_back(b);
            else ov_m = 1'b1;
        end
        repeat (3) tick();
        checks++; if (overrun !== ov_m) begin errors++; $display("FAIL b2b_overrun: got %b expected %b", overrun, ov_m); end
        while (mq.size() != 0) begin
            checks++; if (stdin_valid !== 1'b1 || stdin !== mq[0]) begin errors++; $display("FAIL b2b_data: got v=%b d=%h expected v=1 d=%h", stdin_valid, stdin, mq[0]); end
            pop();
            hd = mq.pop_front();
        end
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", stdin_valid); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] hd;
        int         npop;
        mq.delete();
        ov_m = 1'b0;
        for (int it = 0; it < 12; it++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            repeat (3) tick();
            if (mq.size() < DEPTH) mq.push_back(b);
            else ov_m = 1'b1;
            checks++; if (overrun !== ov_m) begin errors++; $display("FAIL rand_overrun it%0d: got %b expected %b", it, overrun, ov_m); end
            npop = int'($urandom_range(0, 2));
            for (int p = 0; p < npop; p++) begin
                checks++; if (stdin_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid it%0d: got %b expected %b", it, stdin_valid, mq.size() != 0); end
                if (mq.size() != 0) begin
                    checks++; if (stdin !== mq[0]) begin errors++; $display("FAIL rand_data it%0d: got %h expected %h", it, stdin, mq[0]); end
                end
                pop();
                if (mq.size() != 0) begin
                    hd   = mq.pop_front();
                    ov_m = 1'b0;
                end
            end
        end
        while (mq.size() != 0) begin
            checks++; if (stdin_valid !== 1'b1 || stdin !== mq[0]) begin errors++; $display("FAIL rand_drain: got v=%b d=%h expected v=1 d=%h", stdin_valid, stdin, mq[0]); end
            pop();
            hd = mq.pop_front();
        end
        checks++; if (overrun !== 1'b0 || stdin_valid !== 1'b0) begin errors++; $display("FAIL rand_end: got ovr=%b v=%b expected 0 0", overrun, stdin_valid); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hAA;
        send_frame(8'h66, 1'b1);
        repeat (3) tick();
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) tick();
        end
        reset_n = 1'b0;
        rx      = 1'b1;
        #1;
        checks++; if (stdin !== 8'h00 || stdin_valid !== 1'b0) begin errors++; $display("FAIL midrst_out: got v=%b d=%h expected v=0 d=00", stdin_valid, stdin); end
        checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ovr=%b fe=%b expected 0 0", overrun, frame_err); end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (50) tick();
        checks++; if (stdin_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_byte: got %b expected 0", stdin_valid); end
        send_frame(8'h0F, 1'b1);
        repeat (3) tick();
        checks++; if (stdin_valid !== 1'b1 || stdin !== 8'h0F) begin errors++; $display("FAIL midrst_next: got v=%b d=%h expected v=1 d=0f", stdin_valid, stdin); end
        pop();
    endtask

    initial begin
        reset_n   = 1'b0;
        rx        = 1'b1;
        stdin_ren = 1'b0;
        ov_m      = 1'b0;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_simul_pop();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
